// File: rtl/mem_arbiter.sv
// Arbitrates the single memCtrl/PSRAM port between video fetch (port 0) and CPU (port 1), with a watchdog.
// Grant-to-ack takes at least 5 cycles plus memCtrl busy time; a requester holds i_reqN until it sees o_ackN.
module mem_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4095,
  parameter int FAIR    = 1
) (
  input  logic              i_clkRAM,
  input  logic              reset,
  input  logic              i_req0,
  input  logic              i_write0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic              i_bank0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic              i_write1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic              i_bank1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic [DATA_W-1:0] o_rdata0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mc_cs,
  output logic              o_mc_write,
  output logic [ADDR_W-1:0] o_mc_address,
  output logic              o_mc_bank,
  output logic [DATA_W-1:0] o_mc_dataToWrite,
  input  logic [DATA_W-1:0] i_mc_dataRead,
  input  logic              i_mc_busy,
  input  logic              i_mc_dataReady,
  input  logic              i_mc_idle,
  output logic [1:0]        o_grant,
  output logic              o_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              owner;
  logic              last_grant;
  logic              win;
  logic              start;
  logic              done;
  logic              abort;
  logic              wd_hit;
  logic [WD_W-1:0]   wd_cnt;

  // On a tie, round-robin hands the port to whoever did not own it last.
  always_comb begin
    win = i_req1;
    if (i_req0 && i_req1) begin
      win = (FAIR != 0) ? ~last_grant : 1'b0;
    end
  end

  assign wd_hit = (wd_cnt >= WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    o_mc_cs   = 1'b1;
    o_ack0    = 1'b0;
    o_ack1    = 1'b0;
    case (state)
      IDLE: begin
        if (i_mc_idle && !i_mc_busy && (i_req0 || i_req1)) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        o_mc_cs   = 1'b0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wd_hit) begin
          abort     = 1'b1;
          state_nxt = RESPOND;
        end else if (i_mc_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!i_mc_busy && (o_mc_write || i_mc_dataReady)) begin
          done      = 1'b1;
          state_nxt = RESPOND;
        end else if (wd_hit) begin
          abort     = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        o_ack0    = ~owner;
        o_ack1    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last_grant       <= 1'b1;
      o_grant          <= 2'b00;
      o_mc_write       <= 1'b0;
      o_mc_address     <= '0;
      o_mc_bank        <= 1'b0;
      o_mc_dataToWrite <= '0;
      o_rdata0         <= '0;
      o_rdata1         <= '0;
      o_timeout        <= 1'b0;
      wd_cnt           <= '0;
    end else begin
      state <= state_nxt;
      // Requester inputs are captured only here; later changes do not affect the access.
      if (start) begin
        owner            <= win;
        o_grant          <= win ? 2'b10 : 2'b01;
        o_mc_write       <= win ? i_write1 : i_write0;
        o_mc_address     <= win ? i_addr1  : i_addr0;
        o_mc_bank        <= win ? i_bank1  : i_bank0;
        o_mc_dataToWrite <= win ? i_wdata1 : i_wdata0;
      end
      if (state == ISSUE) begin
        wd_cnt <= '0;
      end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (abort) begin
        o_timeout <= 1'b1;
        if (owner) o_rdata1 <= '1;
        else       o_rdata0 <= '1;
      end
      if (done && !o_mc_write) begin
        if (owner) o_rdata1 <= i_mc_dataRead;
        else       o_rdata0 <= i_mc_dataRead;
      end
      if (state == RESPOND) begin
        last_grant <= owner;
        o_grant    <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: dut 0 is round-robin, dut 1 fixed priority; both use a 16-cycle watchdog.
module tb_mem_arbiter;

  typedef struct {
    int         port;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       to;
  } exp_t;

  logic        clkSys = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req0 = '0, req1 = '0, wr0 = '0, wr1 = '0, bank0 = '0, bank1 = '0;
  logic [23:0] addr0 [2];
  logic [23:0] addr1 [2];
  logic [7:0]  wd0 [2];
  logic [7:0]  wd1 [2];
  logic [1:0]  ack0, ack1, cs, mc_wr, mc_bank, tout;
  logic [7:0]  rd0 [2];
  logic [7:0]  rd1 [2];
  logic [23:0] mc_addr [2];
  logic [7:0]  mc_wd [2];
  logic [1:0]  grant [2];
  logic [7:0]  rdat [2];
  logic [1:0]  busy = '0, drdy = '0, idle, hang = '0, notidle = '0;

  int          ms [2];
  int          mcnt [2];
  logic        m_wr [2];
  logic [23:0] m_addr [2];
  logic [7:0]  m_dat [2];
  logic [7:0]  mem [bit [24:0]];

  int          n_chk = 0, n_fail = 0, cyc = 0;
  int          cs_cnt [2];
  logic [23:0] cs_addr [2];
  logic [7:0]  cs_dat [2];
  logic        cs_wr [2];
  int          a0_cnt [2];
  int          a1_cnt [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  always #5 clkSys = ~clkSys;
  always @(posedge clkSys) cyc++;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(.ADDR_W(24), .DATA_W(8), .TIMEOUT(16), .FAIR(k == 0 ? 1 : 0)) u_dut (
      .i_clkRAM(clkSys), .reset(rst),
      .i_req0(req0[k]), .i_write0(wr0[k]), .i_addr0(addr0[k]), .i_bank0(bank0[k]), .i_wdata0(wd0[k]),
      .i_req1(req1[k]), .i_write1(wr1[k]), .i_addr1(addr1[k]), .i_bank1(bank1[k]), .i_wdata1(wd1[k]),
      .o_ack0(ack0[k]), .o_rdata0(rd0[k]), .o_ack1(ack1[k]), .o_rdata1(rd1[k]),
      .o_mc_cs(cs[k]), .o_mc_write(mc_wr[k]), .o_mc_address(mc_addr[k]), .o_mc_bank(mc_bank[k]),
      .o_mc_dataToWrite(mc_wd[k]), .i_mc_dataRead(rdat[k]), .i_mc_busy(busy[k]),
      .i_mc_dataReady(drdy[k]), .i_mc_idle(idle[k]), .o_grant(grant[k]), .o_timeout(tout[k])
    );
  end

  assign idle = {(ms[1] == 0) && !notidle[1], (ms[0] == 0) && !notidle[0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memCtrl model: busy rises one cycle after the strobe, stays high 3 cycles, read data with busy low.
  always @(negedge clkSys) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        ms[k] = 0; busy[k] = 1'b0; drdy[k] = 1'b0;
      end else begin
        case (ms[k])
          0: if (!cs[k] && !hang[k]) begin
               m_wr[k] = mc_wr[k]; m_addr[k] = mc_addr[k]; m_dat[k] = mc_wd[k]; ms[k] = 1;
             end
          1: begin busy[k] = 1'b1; mcnt[k] = 3; ms[k] = 2; end
          2: begin
               mcnt[k]--;
               if (mcnt[k] == 0) begin
                 busy[k] = 1'b0;
                 if (m_wr[k]) mem[{k[0], m_addr[k]}] = m_dat[k];
                 else begin
                   rdat[k] = mem.exists({k[0], m_addr[k]}) ? mem[{k[0], m_addr[k]}] : 8'h00;
                   drdy[k] = 1'b1;
                 end
                 ms[k] = 3;
               end
             end
          default: begin drdy[k] = 1'b0; ms[k] = 0; end
        endcase
      end
    end
  end

  // Monitor: tracks strobes and pops the scoreboard on every acknowledge.
  always @(negedge clkSys) begin
    exp_t e;
    #1;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (!cs[k]) begin
          cs_cnt[k]++; cs_addr[k] = mc_addr[k]; cs_dat[k] = mc_wd[k]; cs_wr[k] = mc_wr[k];
        end
        if (ack0[k] || ack1[k]) begin
          a0_cnt[k] += int'(ack0[k]);
          a1_cnt[k] += int'(ack1[k]);
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ack dut%0d: got acks %b expected none", k, {ack1[k], ack0[k]});
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("ack_port_dut%0d", k), {30'b0, ack1[k], ack0[k]}, (e.port == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rdata0_dut%0d", k), {24'b0, rd0[k]}, {24'b0, e.rd0});
            chk($sformatf("rdata1_dut%0d", k), {24'b0, rd1[k]}, {24'b0, e.rd1});
            chk($sformatf("timeout_dut%0d", k), {31'b0, tout[k]}, {31'b0, e.to});
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int p, input logic [7:0] r0, input logic [7:0] r1, input logic t);
    exp_t e;
    e.port = p; e.rd0 = r0; e.rd1 = r1; e.to = t;
    return e;
  endfunction

  task automatic access(input int d, input int p, input logic w, input logic [23:0] a, input logic [7:0] dat);
    int got = 0;
    @(negedge clkSys); #1;
    if (p == 0) begin wr0[d] = w; addr0[d] = a; wd0[d] = dat; req0[d] = 1'b1; end
    else        begin wr1[d] = w; addr1[d] = a; wd1[d] = dat; req1[d] = 1'b1; end
    for (int i = 0; i < 300 && got == 0; i++) begin
      @(negedge clkSys); #1;
      if ((p == 0 && ack0[d]) || (p == 1 && ack1[d])) begin
        got = 1;
        if (p == 0) req0[d] = 1'b0; else req1[d] = 1'b0;
      end
    end
    chk($sformatf("ack_wait_dut%0d_p%0d", d, p), got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t_cs, t_ack, got, lows, acks;
    int nack [2];
    for (int k = 0; k < 2; k++) begin
      addr0[k] = '0; addr1[k] = '0; wd0[k] = '0; wd1[k] = '0;
      cs_cnt[k] = 0; a0_cnt[k] = 0; a1_cnt[k] = 0; ms[k] = 0; rdat[k] = '0;
    end
    repeat (3) @(negedge clkSys);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_cs_dut%0d", k), {31'b0, cs[k]}, 1);
      chk($sformatf("rst_ack_dut%0d", k), {30'b0, ack1[k], ack0[k]}, 0);
      chk($sformatf("rst_rdata_dut%0d", k), {16'b0, rd1[k], rd0[k]}, 0);
      chk($sformatf("rst_grant_dut%0d", k), {30'b0, grant[k]}, 0);
      chk($sformatf("rst_timeout_dut%0d", k), {31'b0, tout[k]}, 0);
      chk($sformatf("rst_mc_bus_dut%0d", k), {mc_wr[k], mc_bank[k], mc_addr[k]}, 0);
      chk($sformatf("rst_mc_wdata_dut%0d", k), {24'b0, mc_wd[k]}, 0);
    end
    rst = 1'b1;

    // 1: write from port 0
    q0.push_back(mk(0, 8'h00, 8'h00, 1'b0));
    access(0, 0, 1'b1, 24'h001002, 8'hA5);
    repeat (3) @(negedge clkSys);
    #1;
    chk("wr_cs_pulses", cs_cnt[0], 1);
    chk("wr_cs_addr", {8'b0, cs_addr[0]}, 32'h001002);
    chk("wr_cs_data", {24'b0, cs_dat[0]}, 32'hA5);
    chk("wr_cs_write", {31'b0, cs_wr[0]}, 1);
    chk("wr_ack0_once", a0_cnt[0], 1);

    // 2: read back on port 1, port 0 data untouched
    q0.push_back(mk(1, 8'h00, 8'hA5, 1'b0));
    access(0, 1, 1'b0, 24'h001002, 8'h00);
    chk("rd_cs_pulses", cs_cnt[0], 2);

    // 3: tie, both held for four accesses on both arbiters
    q0.push_back(mk(0, 8'h00, 8'hA5, 1'b0)); q0.push_back(mk(1, 8'h00, 8'hA5, 1'b0));
    q0.push_back(mk(0, 8'h00, 8'hA5, 1'b0)); q0.push_back(mk(1, 8'h00, 8'hA5, 1'b0));
    for (int i = 0; i < 4; i++) q1.push_back(mk(0, 8'h00, 8'h00, 1'b0));
    @(negedge clkSys); #1;
    for (int k = 0; k < 2; k++) begin
      wr0[k] = 1'b1; addr0[k] = 24'h000010; wd0[k] = 8'h11;
      wr1[k] = 1'b1; addr1[k] = 24'h000020; wd1[k] = 8'h22;
      req0[k] = 1'b1; req1[k] = 1'b1; nack[k] = 0;
    end
    for (int i = 0; i < 400 && (nack[0] < 4 || nack[1] < 4); i++) begin
      @(negedge clkSys); #1;
      for (int k = 0; k < 2; k++) begin
        if (ack0[k] || ack1[k]) begin
          nack[k]++;
          if (nack[k] == 4) begin req0[k] = 1'b0; req1[k] = 1'b0; end
        end
      end
    end
    chk("tie_acks_fair", nack[0], 4);
    chk("tie_acks_fixed", nack[1], 4);
    chk("fixed_port1_starved", a1_cnt[1], 0);

    // 4: hung memCtrl, watchdog aborts after 16 waiting cycles
    hang[0] = 1'b1;
    q0.push_back(mk(0, 8'hFF, 8'hA5, 1'b1));
    wr0[0] = 1'b0; addr0[0] = 24'h001002; req0[0] = 1'b1;
    t_cs = -1; t_ack = -1;
    for (int i = 0; i < 50 && t_cs < 0; i++) begin
      @(negedge clkSys); #1;
      if (!cs[0]) t_cs = cyc;
    end
    for (int i = 0; i < 50 && t_ack < 0; i++) begin
      @(negedge clkSys); #1;
      if (ack0[0]) begin t_ack = cyc; req0[0] = 1'b0; end
    end
    chk("wd_issue_to_ack", t_ack - t_cs, 17);
    hang[0] = 1'b0;
    q0.push_back(mk(1, 8'hFF, 8'h22, 1'b1));
    access(0, 1, 1'b0, 24'h000020, 8'h00);

    // 5: reset lands in WAIT_DONE
    @(negedge clkSys); #1;
    wr0[0] = 1'b1; addr0[0] = 24'h000030; wd0[0] = 8'h77; req0[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clkSys); #1;
      if (busy[0]) got = 1;
    end
    chk("mid_busy_seen", got, 1);
    @(negedge clkSys); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cs", {31'b0, cs[0]}, 1);
    chk("mid_rst_grant", {30'b0, grant[0]}, 0);
    chk("mid_rst_timeout", {31'b0, tout[0]}, 0);
    req0[0] = 1'b0;
    repeat (2) @(negedge clkSys);
    #1;
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkSys); #1;
      if (ack0[0] || ack1[0]) acks++;
    end
    chk("no_ack_after_rst", acks, 0);

    // 6: memCtrl not idle holds off the grant
    notidle[0] = 1'b1;
    q0.push_back(mk(0, 8'hA5, 8'h00, 1'b0));
    wr0[0] = 1'b0; addr0[0] = 24'h001002; req0[0] = 1'b1;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clkSys); #1;
      if (!cs[0]) lows++;
    end
    chk("cs_held_not_idle", lows, 0);
    notidle[0] = 1'b0;
    @(negedge clkSys); #1;
    chk("grant_first_idle_cs", {31'b0, cs[0]}, 0);
    chk("grant_first_idle_owner", {30'b0, grant[0]}, 1);
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clkSys); #1;
      if (ack0[0]) begin got = 1; req0[0] = 1'b0; end
    end
    chk("notidle_ack", got, 1);

    repeat (5) @(negedge clkSys);
    #1;
    chk("scoreboard0_empty", q0.size(), 0);
    chk("scoreboard1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
